// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES-256 decrypt round sequencer.
package aes_dec_pkg;

    localparam int AES256_NR = 14;

    localparam logic [1:0] MSEL_ARK = 2'd0;
    localparam logic [1:0] MSEL_ISR = 2'd1;
    localparam logic [1:0] MSEL_ISB = 2'd2;
    localparam logic [1:0] MSEL_IMC = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARK0,
        S_ISR,
        S_ISB,
        S_ARK,
        S_IMC,
        S_FISR,
        S_FISB,
        S_FARK,
        S_DONE
    } sched_state_t;

    // Any state that waits on a sub-block handshake.
    function automatic logic is_step(input sched_state_t s);
        return (s != S_IDLE) && (s != S_DONE);
    endfunction

endpackage

// File: rtl/aes_sched_wdog.sv
// Per-step watchdog: counts cycles spent in one step state, flags TIMEOUT.
module aes_sched_wdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + CW'(1);
    end

    // Fires in the TIMEOUT-th cycle of the step.
    assign o_timeout = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/aes_dec_round_sched.sv
// AES-256 inverse-cipher round sequencer; optional watchdog under AES_SCHED_WDOG_EN.
module aes_dec_round_sched
    import aes_dec_pkg::*;
#(
    parameter int NR      = AES256_NR,
    parameter int TIMEOUT = 1023
) (
    input  logic       ap_clk,
    input  logic       ap_rst,
    input  logic       ap_start,
    output logic       ap_done,
    output logic       ap_idle,
    output logic       ap_ready,
    output logic       ark_start,
    output logic [4:0] ark_n,
    input  logic       ark_ready,
    output logic       isr_start,
    input  logic       isr_ready,
    output logic       isb_start,
    input  logic       isb_ready,
    output logic       imc_start,
    input  logic       imc_ready,
    output logic [1:0] mem_sel,
    output logic [4:0] round,
    output logic       err
);
    sched_state_t r_state, w_state_nxt;
    logic [4:0]   r_round, w_round_nxt;
    logic         w_wdog_to;

`ifdef AES_SCHED_WDOG_EN
    logic w_step, w_chg;
    assign w_step = is_step(r_state);
    assign w_chg  = (w_state_nxt != r_state);

    aes_sched_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .i_clk     (ap_clk),
        .i_rst     (ap_rst),
        .i_en      (w_step),
        .i_clr     (w_chg),
        .o_timeout (w_wdog_to)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT != 0);
    assign w_wdog_to    = 1'b0;
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
            r_round <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        ark_start   = 1'b0;
        isr_start   = 1'b0;
        isb_start   = 1'b0;
        imc_start   = 1'b0;
        ark_n       = '0;
        mem_sel     = MSEL_ARK;
        ap_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    w_round_nxt = 5'(NR - 1);
                    w_state_nxt = S_ARK0;
                end
            end
            S_ARK0: begin
                ark_start = 1'b1;
                ark_n     = 5'(NR);
                if (ark_ready) w_state_nxt = S_ISR;
            end
            S_ISR: begin
                isr_start = 1'b1;
                mem_sel   = MSEL_ISR;
                if (isr_ready) w_state_nxt = S_ISB;
            end
            S_ISB: begin
                isb_start = 1'b1;
                mem_sel   = MSEL_ISB;
                if (isb_ready) w_state_nxt = S_ARK;
            end
            S_ARK: begin
                ark_start = 1'b1;
                ark_n     = r_round;
                if (ark_ready) w_state_nxt = S_IMC;
            end
            S_IMC: begin
                imc_start = 1'b1;
                mem_sel   = MSEL_IMC;
                // Round 1 skips InvMixColumns' successor loop and enters the final round.
                if (imc_ready) begin
                    if (r_round == 5'd1) begin
                        w_state_nxt = S_FISR;
                    end else begin
                        w_round_nxt = r_round - 5'd1;
                        w_state_nxt = S_ISR;
                    end
                end
            end
            S_FISR: begin
                isr_start = 1'b1;
                mem_sel   = MSEL_ISR;
                if (isr_ready) w_state_nxt = S_FISB;
            end
            S_FISB: begin
                isb_start = 1'b1;
                mem_sel   = MSEL_ISB;
                if (isb_ready) w_state_nxt = S_FARK;
            end
            S_FARK: begin
                ark_start = 1'b1;
                ark_n     = 5'd0;
                if (ark_ready) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                ap_done     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A stuck sub-block aborts the run but still completes the ap handshake.
        if (w_wdog_to) begin
            ark_start   = 1'b0;
            isr_start   = 1'b0;
            isb_start   = 1'b0;
            imc_start   = 1'b0;
            w_round_nxt = r_round;
            w_state_nxt = S_DONE;
        end
    end

    assign ap_ready = ap_done;
    assign ap_idle  = (r_state == S_IDLE) && !ap_start;
    assign round    = r_round;
    assign err      = w_wdog_to;

endmodule
